pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM).
//  - Decides per cycle whether each stage advances, holds, or is flushed to a bubble.
//  - Covers three events: data-memory wait, branch/jump redirect resolved in MEM,
//    and load-use hazards.
//  - Also keeps a saturating stall counter and a data-memory timeout watchdog.
// PARAMETERS
//  REG_W       5    register-index width
//  CNT_W       16   stall_count width
//  MEM_TIMEOUT 64   max consecutive MEM_WAIT cycles before HALT (>=2)
// PORTS
//  clk             in   1      pipeline clock, rising edge
//  rst_n           in   1      asynchronous reset, active low
//  ID_rs           in   REG_W  rs of instruction in ID
//  ID_rt           in   REG_W  rt of instruction in ID
//  ID_uses_rt      in   1      ID instruction reads rt
//  MemRead_EX      in   1      EX instruction is a load
//  Write_register_EX in REG_W  destination of EX instruction
//  Branch_MEM      in   1      MEM instruction is a branch
//  Zero_MEM        in   1      ALU zero flag for MEM instruction
//  Jump_MEM        in   1      MEM instruction is a jump
//  MemRead_MEM     in   1      MEM instruction reads data memory
//  MemWrite_MEM    in   1      MEM instruction writes data memory
//  dmem_ready      in   1      data memory completes access this cycle
//  pc_en           out  1      PC loads next value
//  if_id_en        out  1      IF/ID register loads
//  if_id_flush     out  1      IF/ID loads bubble (all zero)
//  id_ex_en        out  1      ID/EX register loads
//  id_ex_flush     out  1      ID/EX loads bubble
//  ex_mem_en       out  1      EX/MEM register loads
//  ex_mem_flush    out  1      EX/MEM loads bubble
//  pc_sel_mem      out  1      PC takes branch/jump target from MEM
//  dmem_req        out  1      data-memory request strobe
//  halted          out  1      sticky watchdog trip
//  stall_count     out  CNT_W  cycles with pc_en=0, saturating at all-ones
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - state=RUN, wait_cnt=0, stall_count=0, halted=0.
//    - All outputs forced to 0 while rst_n is low; this gating is combinational.
//  - Outputs are combinational from state and inputs; no added latency.
//  - Flush wins over en: with flush=1 the register loads a bubble regardless of en.
//  - mem_acc = MemRead_MEM | MemWrite_MEM.
//  - taken = (Branch_MEM & Zero_MEM) | Jump_MEM.
//  - lu = MemRead_EX & (Write_register_EX!=0) &
//         ((ID_rs==Write_register_EX) | (ID_uses_rt & ID_rt==Write_register_EX)).
//  - RUN:
//    - dmem_req = mem_acc.
//    - Freeze when mem_acc & !dmem_ready:
//      - all en=0, no flush, pc_sel_mem=0.
//      - Go to MEM_WAIT with wait_cnt=1.
//    - Else redirect when taken:
//      - pc_sel_mem=1, pc_en=1.
//      - if_id_flush, id_ex_flush and ex_mem_flush all 1.
//      - lu is ignored because the redirect beats the load-use stall.
//    - Else load-use stall when lu:
//      - pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
//      - Exactly one bubble; WB forwarding covers the rest.
//    - Else all en=1, no flush.
//  - MEM_WAIT:
//    - dmem_req=1 held; all en=0 until dmem_ready.
//    - On dmem_ready, the same cycle behaves exactly as RUN with the access complete
//      (redirect/lu priority as above), and next state is RUN.
//    - Otherwise wait_cnt increments.
//    - When wait_cnt reaches MEM_TIMEOUT without ready: go to HALT, set halted=1.
//  - HALT:
//    - All en=0, flush=0, dmem_req=0.
//    - Only rst_n exits this state.
//  - stall_count increments every cycle pc_en=0 in RUN/MEM_WAIT (HALT excluded).
//    It holds at 2^CNT_W-1.
//  - Simultaneous events:
//    - Memory freeze > redirect > load-use.
//    - A redirect on the same cycle as dmem_ready is honoured that cycle.
//  - Reset mid-MEM_WAIT: returns to RUN immediately and drops dmem_req asynchronously.
// STRUCTURE
//  - pipeline_ctrl_pkg holds:
//    - state encoding localparams ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_HALT=2'd2;
//    - REG_W default;
//    - the bubble value (32'h0).
//  - Sub-module hazard_detect: combinational lu compare (ID_rs/ID_rt/ID_uses_rt vs
//    EX dest). Reused later by the forwarding unit.
//  - Top holds the FSM, wait_cnt, stall_count and output decode.
// TESTING
//  1. Reset: rst_n=0 mid-run -> all outputs 0, stall_count=0.
//     After release with no hazards: pc_en=if_id_en=id_ex_en=ex_mem_en=1.
//  2. Load-use: MemRead_EX=1, Write_register_EX=5, ID_rs=5.
//     -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1.
//     Also check Write_register_EX=0 -> no stall.
//  3. Branch taken: Branch_MEM=1, Zero_MEM=1, lu also true.
//     -> pc_sel_mem=1, all three flushes=1, no stall.
//     Also check Zero_MEM=0 -> normal advance.
//  4. Memory wait: MemRead_MEM=1, dmem_ready low for 3 cycles.
//     -> dmem_req=1 and all en=0 for 3 cycles, then advance on the ready cycle.
//     stall_count=3.
//  5. Timeout: MEM_TIMEOUT=4, dmem_ready never rises.
//     -> halted=1 after 4 wait cycles; outputs stay frozen until rst_n pulse.
//  6. Saturation: CNT_W=3 with 10 stall cycles -> stall_count=7.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// default register-index width and the bubble value loaded on a flush.
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam int unsigned REG_W_DEFAULT = 5;

    // Value a pipeline register takes when flushed; a bubble's dest field is r0.
    localparam logic [31:0] BUBBLE = 32'h0;

    typedef enum logic [1:0] {
        StRun     = ST_RUN,
        StMemWait = ST_MEM_WAIT,
        StHalt    = ST_HALT
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: instruction in ID reads the register that the load
// currently in EX is about to write. Purely combinational.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] Write_register_EX,
    output logic             load_use
);

    logic dest_live;
    logic rs_match;
    logic rt_match;

    // r0 (also the dest of a bubble) never carries a dependency.
    always_comb begin
        dest_live = (Write_register_EX != BUBBLE[REG_W-1:0]);
        rs_match  = (ID_rs == Write_register_EX);
        rt_match  = ID_uses_rt && (ID_rt == Write_register_EX);
        load_use  = MemRead_EX && dest_live && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: per-cycle advance/hold/flush decisions for
// IF/ID, ID/EX and EX/MEM, covering data-memory wait, MEM-stage redirects and
// load-use stalls, plus a saturating stall counter and a memory watchdog.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = REG_W_DEFAULT,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] Write_register_EX,
    input  logic             Branch_MEM,
    input  logic             Zero_MEM,
    input  logic             Jump_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             pc_sel_mem,
    output logic             dmem_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               halted_q, halted_d;

    logic lu;
    logic mem_acc;
    logic taken;
    logic decide;

    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
    logic ex_mem_en_c, ex_mem_flush_c, pc_sel_mem_c, dmem_req_c;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .ID_rs             (ID_rs),
        .ID_rt             (ID_rt),
        .ID_uses_rt        (ID_uses_rt),
        .MemRead_EX        (MemRead_EX),
        .Write_register_EX (Write_register_EX),
        .load_use          (lu)
    );

    assign mem_acc = MemRead_MEM | MemWrite_MEM;
    assign taken   = (Branch_MEM & Zero_MEM) | Jump_MEM;

    // FSM next state, wait counter and per-stage control decode.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        halted_d       = halted_q;
        decide         = 1'b0;
        pc_en_c        = 1'b0;
        if_id_en_c     = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_en_c    = 1'b0;
        ex_mem_flush_c = 1'b0;
        pc_sel_mem_c   = 1'b0;
        dmem_req_c     = 1'b0;

        unique case (state_q)
            StRun: begin
                dmem_req_c = mem_acc;
                if (mem_acc && !dmem_ready) begin
                    // Freeze the whole pipe; the freeze cycle is the first wait cycle.
                    state_d    = StMemWait;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    decide = 1'b1;
                end
            end
            StMemWait: begin
                dmem_req_c = 1'b1;
                if (dmem_ready) begin
                    decide     = 1'b1;
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Memory not stalling this cycle: redirect beats load-use.
        if (decide) begin
            if (taken) begin
                pc_en_c        = 1'b1;
                pc_sel_mem_c   = 1'b1;
                if_id_en_c     = 1'b1;
                if_id_flush_c  = 1'b1;
                id_ex_en_c     = 1'b1;
                id_ex_flush_c  = 1'b1;
                ex_mem_en_c    = 1'b1;
                ex_mem_flush_c = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID, inject one bubble into EX, let the load move on.
                id_ex_en_c    = 1'b1;
                id_ex_flush_c = 1'b1;
                ex_mem_en_c   = 1'b1;
            end else begin
                pc_en_c     = 1'b1;
                if_id_en_c  = 1'b1;
                id_ex_en_c  = 1'b1;
                ex_mem_en_c = 1'b1;
            end
        end
    end

    // Saturating count of cycles the PC is held, outside HALT.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != StHalt) && !pc_en_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= halted_d;
        end
    end

    // Outputs forced low combinationally while reset is held.
    always_comb begin
        pc_en        = pc_en_c & rst_n;
        if_id_en     = if_id_en_c & rst_n;
        if_id_flush  = if_id_flush_c & rst_n;
        id_ex_en     = id_ex_en_c & rst_n;
        id_ex_flush  = id_ex_flush_c & rst_n;
        ex_mem_en    = ex_mem_en_c & rst_n;
        ex_mem_flush = ex_mem_flush_c & rst_n;
        pc_sel_mem   = pc_sel_mem_c & rst_n;
        dmem_req     = dmem_req_c & rst_n;
        halted       = halted_q & rst_n;
        stall_count  = stall_cnt_q & {CNT_W{rst_n}};
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short watchdog and a narrow
// stall counter so timeout and saturation are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 4;

    // Output vector bit order:
    // [9]pc_en [8]if_id_en [7]if_id_flush [6]id_ex_en [5]id_ex_flush
    // [4]ex_mem_en [3]ex_mem_flush [2]pc_sel_mem [1]dmem_req [0]halted
    localparam logic [9:0] O_ZERO   = 10'b0000000000;
    localparam logic [9:0] O_RUN    = 10'b1101010000;
    localparam logic [9:0] O_LU     = 10'b0000110000;
    localparam logic [9:0] M_LU     = 10'b1110111111;
    localparam logic [9:0] O_REDIR  = 10'b1010101100;
    localparam logic [9:0] M_REDIR  = 10'b1010101111;
    localparam logic [9:0] O_FREEZE = 10'b0000000010;
    localparam logic [9:0] O_RDY    = 10'b1101010010;
    localparam logic [9:0] O_RDYRED = 10'b1010101110;
    localparam logic [9:0] O_HALT   = 10'b0000000001;
    localparam logic [9:0] M_ALL    = 10'b1111111111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] ID_rs, ID_rt, Write_register_EX;
    logic             ID_uses_rt, MemRead_EX;
    logic             Branch_MEM, Zero_MEM, Jump_MEM, MemRead_MEM, MemWrite_MEM, dmem_ready;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic             ex_mem_en, ex_mem_flush, pc_sel_mem, dmem_req, halted;
    logic [CNT_W-1:0] stall_count;
    logic [9:0]       outs;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, ex_mem_flush, pc_sel_mem, dmem_req, halted};

    pipeline_hazard_ctrl #(
        .REG_W       (REG_W),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ID_rs             (ID_rs),
        .ID_rt             (ID_rt),
        .ID_uses_rt        (ID_uses_rt),
        .MemRead_EX        (MemRead_EX),
        .Write_register_EX (Write_register_EX),
        .Branch_MEM        (Branch_MEM),
        .Zero_MEM          (Zero_MEM),
        .Jump_MEM          (Jump_MEM),
        .MemRead_MEM       (MemRead_MEM),
        .MemWrite_MEM      (MemWrite_MEM),
        .dmem_ready        (dmem_ready),
        .pc_en             (pc_en),
        .if_id_en          (if_id_en),
        .if_id_flush       (if_id_flush),
        .id_ex_en          (id_ex_en),
        .id_ex_flush       (id_ex_flush),
        .ex_mem_en         (ex_mem_en),
        .ex_mem_flush      (ex_mem_flush),
        .pc_sel_mem        (pc_sel_mem),
        .dmem_req          (dmem_req),
        .halted            (halted),
        .stall_count       (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [9:0] exp, input logic [9:0] mask);
        chk(tag, {22'b0, outs & mask}, {22'b0, exp & mask});
    endtask

    task automatic chk_cnt(input string tag, input int unsigned exp);
        chk(tag, {29'b0, stall_count}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = '0; ID_rt = '0; ID_uses_rt = 1'b0; MemRead_EX = 1'b0;
        Write_register_EX = '0; Branch_MEM = 1'b0; Zero_MEM = 1'b0; Jump_MEM = 1'b0;
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu();
        MemRead_EX = 1'b1; Write_register_EX = 5'd5; ID_rs = 5'd5;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk_outs("reset_outs", O_ZERO, M_ALL);
        chk_cnt("reset_cnt", 0);
        tick();
        rst_n = 1'b1;
        #2;
        chk_outs("run_after_reset", O_RUN, M_ALL);

        // Load-use on rs: one stall cycle.
        set_lu();
        #2;
        chk_outs("lu_rs", O_LU, M_LU);
        tick();
        clear_inputs();
        #1;
        chk_cnt("lu_cnt", 1);
        chk_outs("lu_released", O_RUN, M_ALL);

        // Load writing r0 is never a hazard.
        MemRead_EX = 1'b1; Write_register_EX = 5'd0; ID_rs = 5'd0;
        #2;
        chk_outs("lu_r0", O_RUN, M_ALL);

        // rt dependency only counts when rt is actually read.
        ID_rs = 5'd3; ID_rt = 5'd7; Write_register_EX = 5'd7; ID_uses_rt = 1'b1;
        #2;
        chk_outs("lu_rt", O_LU, M_LU);
        ID_uses_rt = 1'b0;
        #2;
        chk_outs("lu_rt_unused", O_RUN, M_ALL);
        tick();
        clear_inputs();

        // Taken branch beats a simultaneous load-use.
        set_lu();
        Branch_MEM = 1'b1; Zero_MEM = 1'b1;
        #2;
        chk_outs("branch_taken", O_REDIR, M_REDIR);
        tick();
        chk_cnt("branch_no_stall", 1);
        clear_inputs();
        Branch_MEM = 1'b1;
        #2;
        chk_outs("branch_not_taken", O_RUN, M_ALL);
        Branch_MEM = 1'b0; Jump_MEM = 1'b1;
        #2;
        chk_outs("jump", O_REDIR, M_REDIR);
        tick();
        clear_inputs();

        // Reset mid-run clears the counter and gates outputs.
        #2 rst_n = 1'b0;
        MemRead_MEM = 1'b1;
        #1;
        chk_outs("midrun_reset_outs", O_ZERO, M_ALL);
        chk_cnt("midrun_reset_cnt", 0);
        rst_n = 1'b1;
        clear_inputs();
        tick();

        // Memory wait: three not-ready cycles then advance.
        MemRead_MEM = 1'b1;
        #2;
        chk_outs("mem_freeze0", O_FREEZE, M_ALL);
        tick();
        chk_outs("mem_freeze1", O_FREEZE, M_ALL);
        tick();
        chk_outs("mem_freeze2", O_FREEZE, M_ALL);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk_outs("mem_ready", O_RDY, M_ALL);
        chk_cnt("mem_wait_cnt", 3);
        tick();
        clear_inputs();
        #1;
        chk_outs("mem_back_run", O_RUN, M_ALL);

        // Redirect on the ready cycle is honoured.
        MemWrite_MEM = 1'b1;
        tick();
        chk_cnt("mem_write_wait_cnt", 4);
        dmem_ready = 1'b1; Jump_MEM = 1'b1;
        #1;
        chk_outs("ready_redirect", O_RDYRED, M_REDIR);
        tick();
        clear_inputs();
        #1;
        chk_outs("after_ready_redirect", O_RUN, M_ALL);

        // Watchdog: ready never arrives.
        reset_pulse();
        MemRead_MEM = 1'b1;
        tick();
        tick();
        tick();
        chk_outs("timeout_pre", O_FREEZE, M_ALL);
        tick();
        chk_outs("timeout_halt", O_HALT, M_ALL);
        chk_cnt("timeout_cnt", 4);
        clear_inputs();
        dmem_ready = 1'b1;
        tick();
        tick();
        chk_outs("halt_sticky", O_HALT, M_ALL);
        chk_cnt("halt_cnt_frozen", 4);
        reset_pulse();
        chk_outs("halt_cleared", O_RUN, M_ALL);
        clear_inputs();

        // Reset while waiting drops dmem_req at once and lands in RUN.
        MemRead_MEM = 1'b1;
        tick();
        MemRead_MEM = 1'b0;
        #1;
        chk_outs("wait_holds_req", O_FREEZE, M_ALL);
        rst_n = 1'b0;
        #1;
        chk_outs("wait_reset_req", O_ZERO, M_ALL);
        rst_n = 1'b1;
        #1;
        chk_outs("wait_reset_run", O_RUN, M_ALL);

        // Saturation: ten stall cycles on a 3-bit counter.
        tick();
        set_lu();
        for (int i = 0; i < 10; i++) tick();
        chk_cnt("saturate", 7);
        clear_inputs();
        tick();
        chk_cnt("saturate_hold", 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
